// File: rtl/lfsr_seq_ctrl_if.sv
// Control/status bundle between the board/LFSR side (master) and the
// sequencing controller (slave).
interface lfsr_seq_ctrl_if #(
   parameter int unsigned PER_W = 5
);
   logic [3:0]       seed;
   logic             load;
   logic             start;
   logic             stop;
   logic             step;
   logic [3:0]       lfsr_q;
   logic             sel;
   logic             tick;
   logic             busy;
   logic [PER_W-1:0] period;
   logic             period_valid;
   logic             err_zero_seed;
   logic             err_lockup;

   modport master (
      output seed, load, start, stop, step, lfsr_q,
      input  sel, tick, busy, period, period_valid, err_zero_seed, err_lockup
   );

   modport slave (
      input  seed, load, start, stop, step, lfsr_q,
      output sel, tick, busy, period, period_valid, err_zero_seed, err_lockup
   );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for a 4-bit seedable LFSR: slow-tick generation,
// seed load, run/stop/single-step, period measurement and lock-up detection.
module lfsr_seq_ctrl #(
   parameter int unsigned DIV   = 4,
   parameter int unsigned DIV_W = 8,
   parameter int unsigned PER_W = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   lfsr_seq_ctrl_if.slave bus_io
);

   typedef enum logic [2:0] {StIdle, StLoad, StArmed, StRun, StHalt} state_e;

   localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIV - 1);
   localparam logic [PER_W-1:0] CntMax  = '1;

   state_e           state_q;
   logic [3:0]       seed_q;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic [PER_W-1:0] cnt_q;
   logic [PER_W-1:0] cnt_d;
   logic [PER_W-1:0] cnt_base;
   logic [PER_W-1:0] period_q;
   logic             sel_q;
   logic             tick_q;
   logic             busy_q;
   logic             pv_q;
   logic             chk_q;
   logic             err_zero_q;
   logic             err_lock_q;

   logic load_ok;
   logic load_bad;
   logic chk_match;
   logic chk_zero;

   always_comb begin
      load_ok   = bus_io.load && (bus_io.seed != 4'h0);
      load_bad  = bus_io.load && (bus_io.seed == 4'h0);
      chk_match = chk_q && (bus_io.lfsr_q == seed_q);
      chk_zero  = chk_q && (bus_io.lfsr_q == 4'h0);
      div_d     = (div_q == DivLast) ? '0 : div_q + DIV_W'(1);
      // A match restarts the count; a tick landing on the same edge opens the new period.
      cnt_base  = chk_match ? '0 : cnt_q;
      cnt_d     = cnt_base;
      if (tick_q && !sel_q && (cnt_base != CntMax)) begin
         cnt_d = cnt_base + PER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         seed_q     <= '0;
         div_q      <= '0;
         cnt_q      <= '0;
         period_q   <= '0;
         sel_q      <= 1'b0;
         tick_q     <= 1'b0;
         busy_q     <= 1'b0;
         pv_q       <= 1'b0;
         chk_q      <= 1'b0;
         err_zero_q <= 1'b0;
         err_lock_q <= 1'b0;
      end else begin
         sel_q  <= 1'b0;
         tick_q <= 1'b0;
         busy_q <= 1'b0;
         pv_q   <= 1'b0;
         chk_q  <= tick_q && !sel_q;
         if (load_bad) begin
            err_zero_q <= 1'b1;
         end
         if (load_ok) begin
            state_q    <= StLoad;
            seed_q     <= bus_io.seed;
            sel_q      <= 1'b1;
            tick_q     <= 1'b1;
            err_zero_q <= 1'b0;
            err_lock_q <= 1'b0;
            cnt_q      <= '0;
            div_q      <= '0;
            chk_q      <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: ;
               StLoad: state_q <= StArmed;
               StArmed: begin
                  cnt_q <= cnt_d;
                  if (chk_match) begin
                     period_q <= cnt_q;
                     pv_q     <= 1'b1;
                  end
                  if (chk_zero) begin
                     err_lock_q <= 1'b1;
                     state_q    <= StHalt;
                  end else if (bus_io.stop) begin
                     state_q <= StArmed;
                  end else if (bus_io.start) begin
                     state_q <= StRun;
                     div_q   <= '0;
                     busy_q  <= 1'b1;
                  end else if (bus_io.step) begin
                     tick_q <= 1'b1;
                  end
               end
               StRun: begin
                  cnt_q <= cnt_d;
                  if (chk_match) begin
                     period_q <= cnt_q;
                     pv_q     <= 1'b1;
                  end
                  if (chk_zero) begin
                     err_lock_q <= 1'b1;
                     state_q    <= StHalt;
                  end else if (bus_io.stop) begin
                     state_q <= StArmed;
                     div_q   <= '0;
                  end else begin
                     busy_q <= 1'b1;
                     div_q  <= div_d;
                     tick_q <= (div_d == DivLast);
                  end
               end
               StHalt: ;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus_io.sel           = sel_q;
   assign bus_io.tick          = tick_q;
   assign bus_io.busy          = busy_q;
   assign bus_io.period        = period_q;
   assign bus_io.period_valid  = pv_q;
   assign bus_io.err_zero_seed = err_zero_q;
   assign bus_io.err_lockup    = err_lock_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural x^4+x^3+1 LFSR closing
// the feedback loop.
module tb_lfsr_seq_ctrl;

   localparam int unsigned DIV   = 4;
   localparam int unsigned DIV_W = 8;
   localparam int unsigned PER_W = 5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] lfsr_reg;
   logic       force_zero = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n, tick_n, busy_n, pv_n, first_tick, first_pv, last_pv;
   int unsigned last_period;
   bit seen;

   always #5 clk = ~clk;

   lfsr_seq_ctrl_if #(.PER_W(PER_W)) bus ();

   lfsr_seq_ctrl #(
      .DIV   (DIV),
      .DIV_W (DIV_W),
      .PER_W (PER_W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_reg <= 4'h0;
      else if (bus.tick) lfsr_reg <= bus.sel ? bus.seed : {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
   end

   assign bus.lfsr_q = force_zero ? 4'h0 : lfsr_reg;

   task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic stats_clear();
      cyc_n = 0; tick_n = 0; busy_n = 0; pv_n = 0;
      first_tick = 0; first_pv = 0; last_pv = 0; last_period = 0;
   endtask

   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      if (bus.tick) begin
         tick_n++;
         if (first_tick == 0) first_tick = cyc_n;
      end
      if (bus.busy) busy_n++;
      if (bus.period_valid) begin
         pv_n++;
         if (first_pv == 0) first_pv = cyc_n;
         last_pv     = cyc_n;
         last_period = bus.period;
      end
   endtask

   task automatic pulse(input logic [3:0] s, input bit ld, input bit sta, input bit sto,
                        input bit ste);
      if (ld) bus.seed = s;
      bus.load = ld; bus.start = sta; bus.stop = sto; bus.step = ste;
      cyc();
      bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
   endtask

   task automatic wait_tick(input int max_cyc, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         cyc();
         if (bus.tick) begin
            hit = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bus.seed = 4'h0; bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
      stats_clear();
      repeat (2) @(negedge clk);
      check_eq("rst_sel", bus.sel, 0);
      check_eq("rst_tick", bus.tick, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_period", bus.period, 0);
      check_eq("rst_errs", {bus.err_zero_seed, bus.err_lockup, bus.period_valid}, 0);
      rst_n = 1'b1;

      // Load 0001: one LOAD cycle, then quiet in ARMED.
      pulse(4'b0001, 1, 0, 0, 0);
      check_eq("load1_sel", bus.sel, 1);
      check_eq("load1_tick", bus.tick, 1);
      cyc();
      check_eq("armed1_sel", bus.sel, 0);
      check_eq("load1_lfsr", bus.lfsr_q, 4'b0001);
      stats_clear();
      repeat (20) cyc();
      check_eq("armed1_ticks", tick_n, 0);
      check_eq("armed1_busy", busy_n, 0);

      // Free run from 1001: tick every DIV cycles, period 15 every 60 cycles.
      pulse(4'b1001, 1, 0, 0, 0);
      cyc();
      stats_clear();
      pulse(4'h0, 0, 1, 0, 0);
      repeat (125) cyc();
      check_eq("run_first_tick", first_tick, 4);
      check_eq("run_tick_cnt", tick_n, 31);
      check_eq("run_busy_cnt", busy_n, 126);
      check_eq("run_pv_cnt", pv_n, 2);
      check_eq("run_pv_first", first_pv, 62);
      check_eq("run_pv_last", last_pv, 122);
      check_eq("run_period", last_period, 15);

      // stop+start together in RUN -> ARMED, no ticks, period retained.
      stats_clear();
      pulse(4'h0, 0, 1, 1, 0);
      repeat (19) cyc();
      check_eq("stopstart_ticks", tick_n, 0);
      check_eq("stopstart_busy", busy_n, 0);
      check_eq("stopstart_period", bus.period, 15);

      // Three single steps from 0110: 0110 -> 1101 -> 1010 -> 0101.
      stats_clear();
      pulse(4'b0110, 1, 0, 0, 0);
      cyc();
      check_eq("load3_ticks", tick_n, 1);
      stats_clear();
      for (int k = 0; k < 3; k++) begin
         pulse(4'h0, 0, 0, 0, 1);
         repeat (4) cyc();
      end
      check_eq("step_ticks", tick_n, 3);
      check_eq("step_busy", busy_n, 0);
      check_eq("step_pv", pv_n, 0);
      check_eq("step_lfsr", bus.lfsr_q, 4'b0101);

      // Zero seed from IDLE.
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      stats_clear();
      pulse(4'h0, 1, 0, 0, 0);
      check_eq("zseed_err", bus.err_zero_seed, 1);
      pulse(4'h0, 0, 1, 0, 0);
      repeat (8) cyc();
      check_eq("zseed_ticks", tick_n, 0);
      check_eq("zseed_busy", busy_n, 0);
      check_eq("zseed_sticky", bus.err_zero_seed, 1);
      pulse(4'b0011, 1, 0, 0, 0);
      check_eq("zseed_clear", bus.err_zero_seed, 0);
      check_eq("zseed_load_sel", bus.sel, 1);
      cyc();
      check_eq("zseed_lfsr", bus.lfsr_q, 4'b0011);

      // Lock-up: force lfsr_q to 0 after the first RUN tick.
      stats_clear();
      pulse(4'h0, 0, 1, 0, 0);
      wait_tick(10, seen);
      check_eq("lock_first_tick", first_tick, 4);
      force_zero = 1'b1;
      cyc();
      cyc();
      check_eq("lock_err", bus.err_lockup, 1);
      check_eq("lock_busy", bus.busy, 0);
      stats_clear();
      pulse(4'h0, 0, 1, 0, 1);
      repeat (14) cyc();
      check_eq("halt_ticks", tick_n, 0);
      check_eq("halt_busy", busy_n, 0);
      force_zero = 1'b0;
      pulse(4'b1111, 1, 0, 0, 0);
      check_eq("recover_err", bus.err_lockup, 0);
      check_eq("recover_tick", bus.tick, 1);
      cyc();
      check_eq("recover_lfsr", bus.lfsr_q, 4'b1111);
      stats_clear();
      pulse(4'h0, 0, 0, 0, 1);
      cyc();
      check_eq("recover_step", tick_n, 1);
      check_eq("recover_step_lfsr", bus.lfsr_q, 4'b1110);

      // load+stop in RUN -> LOAD.
      pulse(4'h0, 0, 1, 0, 0);
      repeat (6) cyc();
      check_eq("run2_busy", bus.busy, 1);
      pulse(4'b1001, 1, 0, 1, 0);
      check_eq("ldstop_sel", bus.sel, 1);
      check_eq("ldstop_tick", bus.tick, 1);
      check_eq("ldstop_busy", bus.busy, 0);
      cyc();
      check_eq("ldstop_lfsr", bus.lfsr_q, 4'b1001);

      // Asynchronous reset in the middle of a RUN tick.
      pulse(4'h0, 0, 1, 0, 0);
      wait_tick(10, seen);
      check_eq("mid_tick_seen", seen, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_tick", bus.tick, 0);
      check_eq("mid_rst_busy", bus.busy, 0);
      check_eq("mid_rst_sel", bus.sel, 0);
      check_eq("mid_rst_misc", {bus.period, bus.period_valid, bus.err_zero_seed, bus.err_lockup}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
